// File: rtl/nine_key_matrix_scanner.sv
// Scans a 3x3 active-low key matrix one row at a time and debounces whole 9-key frames.
// Define GHOST_REJECT_EN to discard frames whose rows share two or more pressed columns.
module nine_key_matrix_scanner #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       scan_en_i,
  input  logic [2:0] col_in_i,
  output logic [2:0] row_out_o,
  output logic [8:0] keys_o,
  output logic       key_changed_o,
  output logic       frame_done_o,
  output logic       ghost_o
);

  localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CntReload = CW'(SETTLE_CYCLES - 1);
  localparam logic [3:0] DebTarget = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, COMMIT} state_e;

  state_e        state_q, state_d;
  logic [1:0]    row_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    sync1_q, sync2_q;
  logic [8:0]    raw_q, prev_q, prev_d, keys_q;
  logic [3:0]    stable_q, stable_d;
  logic          key_changed_q, frame_done_q;
  logic          is_ghost, keys_update;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
    end else begin
      sync1_q <= col_in_i;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Leaving scan_en low aborts any partial frame, but a frame already at COMMIT finishes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (scan_en_i) state_d = SETTLE;
      SETTLE:  if (!scan_en_i) state_d = IDLE;
               else if (cnt_q == '0) state_d = SAMPLE;
      SAMPLE:  if (!scan_en_i) state_d = IDLE;
               else if (row_q == 2'd0) state_d = COMMIT;
               else state_d = SETTLE;
      COMMIT:  state_d = scan_en_i ? SETTLE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    row_out_o = 3'b111;
    if (state_q == SETTLE || state_q == SAMPLE) begin
      row_out_o = ~(3'b001 << row_q);
    end
  end

`ifdef GHOST_REJECT_EN
  function automatic logic two_of_three(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  assign is_ghost = two_of_three(raw_q[8:6] & raw_q[5:3]) |
                    two_of_three(raw_q[8:6] & raw_q[2:0]) |
                    two_of_three(raw_q[5:3] & raw_q[2:0]);
`else
  assign is_ghost = 1'b0;
`endif

  // Debounce decision for the frame just assembled; only used while in COMMIT.
  always_comb begin
    prev_d   = prev_q;
    stable_d = stable_q;
    if (is_ghost) begin
      stable_d = 4'd0;
    end else if (raw_q == prev_q) begin
      stable_d = (stable_q >= DebTarget) ? DebTarget : stable_q + 4'd1;
    end else begin
      prev_d   = raw_q;
      stable_d = 4'd1;
    end
    keys_update = (stable_d == DebTarget) && (prev_d != keys_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q         <= 2'd2;
      cnt_q         <= CntReload;
      raw_q         <= '0;
      prev_q        <= '0;
      stable_q      <= '0;
      keys_q        <= '0;
      key_changed_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      key_changed_q <= 1'b0;
      frame_done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          row_q <= 2'd2;
          cnt_q <= CntReload;
        end
        SETTLE: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        SAMPLE: begin
          if (scan_en_i) begin
            unique case (row_q)
              2'd2:    raw_q[8:6] <= ~sync2_q;
              2'd1:    raw_q[5:3] <= ~sync2_q;
              default: raw_q[2:0] <= ~sync2_q;
            endcase
            if (row_q != 2'd0) begin
              row_q <= row_q - 2'd1;
              cnt_q <= CntReload;
            end
          end
        end
        COMMIT: begin
          row_q         <= 2'd2;
          cnt_q         <= CntReload;
          prev_q        <= prev_d;
          stable_q      <= stable_d;
          frame_done_q  <= 1'b1;
          key_changed_q <= keys_update;
          if (keys_update) keys_q <= prev_d;
        end
        default: ;
      endcase
    end
  end

`ifdef GHOST_REJECT_EN
  logic ghost_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ghost_q <= 1'b0;
    else         ghost_q <= (state_q == COMMIT) && is_ghost;
  end

  assign ghost_o = ghost_q;
`else
  assign ghost_o = 1'b0;
`endif

  assign keys_o        = keys_q;
  assign key_changed_o = key_changed_q;
  assign frame_done_o  = frame_done_q;

endmodule

// File: tb/tb_nine_key_matrix_scanner.sv
// Scoreboard bench for nine_key_matrix_scanner: frames are issued with an expected outcome
// queued from a frame-history model; a monitor pops one expectation per frame_done pulse.
module tb_nine_key_matrix_scanner;

  localparam int SETTLE = 4;
  localparam int DEB    = 3;
`ifdef GHOST_REJECT_EN
  localparam bit GhostEnabled = 1'b1;
`else
  localparam bit GhostEnabled = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstN;
  logic       scanEn;
  logic [2:0] colIn;
  logic [2:0] rowOut;
  logic [8:0] keys;
  logic       keyChanged;
  logic       frameDone;
  logic       ghost;
  logic [8:0] pattern;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [8:0] keys;
    logic       changed;
    logic       ghost;
  } exp_t;

  exp_t       expQ[$];
  int         history[$];
  logic [8:0] modelKeys;

  nine_key_matrix_scanner #(
    .SETTLE_CYCLES (SETTLE),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .scan_en_i    (scanEn),
    .col_in_i     (colIn),
    .row_out_o    (rowOut),
    .keys_o       (keys),
    .key_changed_o(keyChanged),
    .frame_done_o (frameDone),
    .ghost_o      (ghost)
  );

  always #5 clk = ~clk;

  // The matrix: the driven row pulls the columns of its pressed keys low.
  assign colIn = (rowOut == 3'b011) ? ~pattern[8:6] :
                 (rowOut == 3'b101) ? ~pattern[5:3] :
                 (rowOut == 3'b110) ? ~pattern[2:0] : 3'b111;

  task automatic checkOutput(input string name, input logic [8:0] actual, input logic [8:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit isGhostFrame(input logic [8:0] f);
    logic [2:0] r [3];
    r[0] = f[2:0];
    r[1] = f[5:3];
    r[2] = f[8:6];
    for (int a = 0; a < 3; a++)
      for (int b = a + 1; b < 3; b++)
        if ($countones(r[a] & r[b]) >= 2) return 1'b1;
    return 1'b0;
  endfunction

  // Keys follow a frame once the last DEB committed frames are identical and ghost-free.
  task automatic modelCommit(input logic [8:0] f);
    exp_t e;
    bit   g;
    bit   same;
    int   last;
    g = GhostEnabled && isGhostFrame(f);
    history.push_back(g ? -1 : int'(f));
    if (history.size() > 16) void'(history.pop_front());
    e.changed = 1'b0;
    e.ghost   = g;
    last = history[history.size() - 1];
    if (history.size() >= DEB) begin
      same = 1'b1;
      for (int i = history.size() - DEB; i < history.size(); i++)
        if (history[i] != last) same = 1'b0;
      if (same && last >= 0 && 9'(last) != modelKeys) begin
        modelKeys = 9'(last);
        e.changed = 1'b1;
      end
    end
    e.keys = modelKeys;
    expQ.push_back(e);
  endtask

  task automatic modelReset();
    history.delete();
    expQ.delete();
    modelKeys = '0;
  endtask

  task automatic waitFrame();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (frameDone) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL frame_timeout: got no frame_done expected one within 40 cycles");
    end
  endtask

  task automatic applyStimulus(input logic [8:0] f);
    modelCommit(f);
    pattern = f;
    scanEn  = 1'b1;
    waitFrame();
  endtask

  // Release reset with scanning enabled and time the first frame from the first driven row.
  task automatic startAfterReset();
    int startN = -1;
    int doneN  = -1;
    modelCommit(pattern);
    scanEn = 1'b1;
    @(negedge clk);
    rstN = 1'b1;
    for (int n = 1; n <= 40 && doneN < 0; n++) begin
      @(negedge clk);
      if (n == 2) checkOutput("row_out_first_row", {6'd0, rowOut}, 9'h003);
      if (startN < 0 && rowOut != 3'b111) startN = n;
      if (frameDone) doneN = n;
    end
    checkOutput("first_frame_cycles", 9'(doneN - startN), 9'd16);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rstN === 1'b1) begin
      checks++;
      if (!(rowOut inside {3'b111, 3'b011, 3'b101, 3'b110})) begin
        errors++;
        $display("[TB] FAIL row_out_onehot: got %b expected at most one low bit", rowOut);
      end
      if (keyChanged && !frameDone) begin
        errors++;
        $display("[TB] FAIL key_changed_align: got key_changed=1 expected only with frame_done");
      end
      if (frameDone) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_frame_done: got frame_done=1 expected 0 at %0t", $time);
        end else begin
          e = expQ.pop_front();
          checkOutput("keys", keys, e.keys);
          checkOutput("key_changed", {8'd0, keyChanged}, {8'd0, e.changed});
          checkOutput("ghost", {8'd0, ghost}, {8'd0, e.ghost});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test expected finish before 500us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hold;
    logic [8:0] p;
    modelReset();
    rstN    = 1'b0;
    scanEn  = 1'b1;
    pattern = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_row_out", {6'd0, rowOut}, 9'h007);
    checkOutput("reset_keys", keys, 9'h000);
    startAfterReset();

    repeat (13) applyStimulus(9'h010);
    repeat (4) applyStimulus(9'h000);
    repeat (3) begin
      applyStimulus(9'h010);
      applyStimulus(9'h000);
    end
    repeat (4) applyStimulus(9'h010);

    repeat (6) @(negedge clk);
    scanEn = 1'b0;
    @(negedge clk);
    checkOutput("abort_row_out", {6'd0, rowOut}, 9'h007);
    repeat (30) @(negedge clk);
    checkOutput("abort_keys", keys, modelKeys);

    repeat (3) applyStimulus(9'h000);
    repeat (4) applyStimulus(9'h1B0);

    for (int k = 0; k < 14; k++) begin
      p    = 9'($urandom_range(0, 511));
      hold = $urandom_range(1, 4);
      repeat (hold) applyStimulus(p);
    end

    repeat (3) applyStimulus(9'h111);
    repeat (5) @(negedge clk);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midscan_reset_row_out", {6'd0, rowOut}, 9'h007);
    checkOutput("midscan_reset_keys", keys, 9'h000);
    checkOutput("midscan_reset_pulses", {7'd0, keyChanged, frameDone}, 9'h000);
    modelReset();
    pattern = '0;
    repeat (2) @(negedge clk);
    startAfterReset();
    repeat (3) applyStimulus(9'h010);

    scanEn = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("final_keys", keys, 9'h010);
    checkOutput("expectations_drained", 9'(expQ.size()), 9'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nine_key_matrix_scanner.md
Name: nine_key_matrix_scanner

Overview:
- Reader for a 3x3 common-row switch/key matrix: the input-side counterpart of the 9-segment-to-6-pin LED row driver.
- Drives one row low at a time and samples the three column lines.
- Debounces whole 9-key frames and presents a 9-bit key vector in the same bit ordering as the 9-segment display bus, so key state maps 1:1 onto LED segments.

Parameters:
- SETTLE_CYCLES, 4: cycles a row is driven before its columns are sampled. Legal range is 3 or more, which covers the 2-flop column synchronizer.
- DEBOUNCE_SCANS, 3: consecutive identical full frames required before `keys` updates. Legal range is 1 to 15.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- scan_en  in  1  level; 1 = scanning, 0 = idle
- col_in  in  3  column lines, active-low, externally pulled up; asynchronous to clk
- row_out  out  3  row drive, active-low, at most one bit low at a time
- keys  out  9  debounced pressed-key vector, 1 = pressed
- key_changed  out  1  one-cycle pulse when `keys` updates
- frame_done  out  1  one-cycle pulse at the end of every completed frame
- ghost  out  1  one-cycle ghost-frame pulse; tied 0 unless GHOST_REJECT_EN is defined

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. While rst_n=0:
  - row_out=3'b111, keys=0, key_changed=0, frame_done=0, ghost=0
  - synchronizer flops are set to 3'b111
  - raw frame=0, prev frame=0, stable count=0, state=IDLE
- Key mapping: bit index = row*3 + col.
  - row r is driven on row_out[r]; col c is read on col_in[c]
  - bit 8 = row 2 / col 2; bit 0 = row 0 / col 0
  - keys[8:6] = row 2, keys[5:3] = row 1, keys[2:0] = row 0
- col_in path: passes through a 2-flop synchronizer, then is inverted (pressed = 1) before sampling.
- FSM states are IDLE, SETTLE, SAMPLE, COMMIT. Row index `r` scans 2 → 1 → 0.
- IDLE:
  - row_out=111.
  - If scan_en=1, go to SETTLE with r=2 and the settle counter loaded to SETTLE_CYCLES-1.
- SETTLE:
  - row_out drives bit r low.
  - Counter decrements each cycle; at 0, go to SAMPLE.
- SAMPLE (1 cycle, row still driven):
  - raw[r*3 +: 3] <= synchronized, inverted columns.
  - If r>0: r <= r-1, reload the counter, go to SETTLE.
  - If r=0: go to COMMIT.
- COMMIT (1 cycle, row_out=111):
  - If raw==prev: count <= min(count+1, DEBOUNCE_SCANS).
  - Otherwise: prev <= raw and count <= 1.
  - If the new count == DEBOUNCE_SCANS and the new prev != keys: keys <= prev, and key_changed pulses on the next cycle, aligned with the keys update.
  - frame_done pulses on the next cycle.
  - Then go to SETTLE (r=2) if scan_en=1, else IDLE.
- Frame length: 3*(SETTLE_CYCLES+1)+1 cycles, which is 16 at the defaults.
- Update latency: keys updates at the end of the DEBOUNCE_SCANS-th consecutive identical frame.
- scan_en falling in any non-IDLE state other than COMMIT:
  - go to IDLE on the next edge, and row_out=111 from that cycle
  - discard the partial raw frame; prev, count and keys are held
  - no frame_done
- scan_en falling during COMMIT: the commit completes, then the FSM goes to IDLE.
- keys holds its value indefinitely while in IDLE.
- Stable count saturates at DEBOUNCE_SCANS, so there are no repeat key_changed pulses for a held pattern.
- Multiple simultaneous keys are reported as-is; no priority is applied.

Optional Feature:
- Macro: GHOST_REJECT_EN.
- When defined, a frame is a ghost if any two rows share two or more asserted columns (rectangle corners, which are indistinguishable from phantom presses in an undiode'd matrix). At COMMIT, a ghost frame:
  - pulses ghost (aligned with frame_done)
  - sets count <= 0 and leaves prev and keys unchanged
  - is not counted toward debounce
- When undefined: ghost is tied 0 and every frame is treated normally.

Test Plan:
- Reset and start: assert rst_n=0 mid-scan → row_out=111 and keys=0 immediately. Release rst_n with scan_en=1 → row_out=3'b011 on the 2nd edge, and frame_done first pulses 16 cycles after leaving IDLE.
- Single press: pull col_in[1] low whenever row_out[1]=0 (key 4) → keys=9'h010 plus one key_changed pulse at the end of the 3rd frame. No further pulses over 10 more frames.
- Bounce: toggle key 4 on alternating frames for 6 frames, then hold it → keys stays 0 through the toggling, then becomes 9'h010 after 3 consecutive held frames.
- Release and abort:
  - From keys=9'h010, release the key → keys=0 and key_changed after 3 frames.
  - Separately, drop scan_en at cycle 7 of a frame → row_out=111 on the next cycle, no frame_done, keys unchanged.
- Ghost: press keys 8, 7 and 5, so the raw frame also shows key 4.
  - Without GHOST_REJECT_EN: keys=9'h1B0 after 3 frames.
  - With GHOST_REJECT_EN: ghost pulses every frame and keys stays 0.
